// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared constants and state encoding for the sequential divider
package seq_divider_pkg;

    // Active-low 7-segment glyphs shared with the carry and overflow digits
    localparam logic [6:0] SEG_DIGIT_0 = 7'b1000000;
    localparam logic [6:0] SEG_DIGIT_1 = 7'b1111001;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DBZ    = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// rtl/seq_divider_div_step.sv - one combinational restoring-division iteration
module seq_divider_div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    // Partial remainder shifted left with the next dividend bit; needs one extra bit
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] shifted_low;

    assign shifted     = {rem, q_msb};
    assign shifted_low = shifted[WIDTH-1:0];

    // Trial subtraction succeeds when the shifted remainder covers the divisor.
    // On success the true difference is below the divisor, so WIDTH bits suffice.
    assign q_bit    = (shifted >= {1'b0, divisor});
    assign rem_next = q_bit ? (shifted_low - divisor) : shifted_low;

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring divider with start/done handshake
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic [2*WIDTH-1:0] result,
    output logic [6:0]         dbz_seg
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_d;
    logic             accept;
    logic             finish;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] step_rem;
    logic             step_bit;
    logic [WIDTH-1:0] quo_next;

    seq_divider_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem      (rem_r),
        .q_msb    (quo_r[WIDTH-1]),
        .divisor  (dvs_r),
        .rem_next (step_rem),
        .q_bit    (step_bit)
    );

    assign quo_next = {quo_r[WIDTH-2:0], step_bit};
    assign busy     = (state == DIVIDE) || (state == DBZ);
    assign result   = {remainder, quotient};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic; start is only looked at while idle
    always_comb begin
        state_d = state;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = (divisor != '0) ? DIVIDE : DBZ;
                end
            end
            DIVIDE: begin
                if (cnt == CNT_LAST) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            DBZ: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture, iteration registers and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            dvs_r     <= '0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz_seg   <= SEG_DIGIT_0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                rem_r <= '0;
                quo_r <= dividend;
                dvs_r <= divisor;
                cnt   <= '0;
            end else if (state == DIVIDE) begin
                rem_r <= step_rem;
                quo_r <= quo_next;
                cnt   <= cnt + CNT_W'(1);
                if (finish) begin
                    quotient  <= quo_next;
                    remainder <= step_rem;
                    dbz_seg   <= SEG_DIGIT_0;
                    done      <= 1'b1;
                end
            end else if (state == DBZ) begin
                // Working quotient still holds the captured dividend here
                quotient  <= '1;
                remainder <= quo_r;
                dbz_seg   <= SEG_DIGIT_1;
                done      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed and sweep bench for seq_divider
module tb_seq_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic [7:0] result;
    logic [6:0] dbz_seg;

    int n_tests = 0;
    int n_fail  = 0;

    seq_divider #(
        .WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .result    (result),
        .dbz_seg   (dbz_seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait at negedges for done; returns cycles counted from the accepting edge
    task automatic wait_done(output int lat);
        int cyc;
        cyc = 1;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        lat = cyc - 1;
    endtask

    // Called at a negedge; issues one request and checks the completion
    task automatic run_div(input logic [3:0] a, input logic [3:0] b, input string tag);
        logic [3:0] eq;
        logic [3:0] er;
        logic [6:0] es;
        int         elat;
        int         lat;
        if (b == 4'd0) begin
            eq = 4'hF; er = a; es = 7'b1111001; elat = 1;
        end else begin
            eq = a / b; er = a % b; es = 7'b1000000; elat = 4;
        end
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check({tag, "_done"}, done, 1);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
        check({tag, "_res"}, result, {er, eq});
        check({tag, "_seg"}, dbz_seg, es);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int lat;
        int seen;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_res", result, 0);
        check("rst_seg", dbz_seg, 7'b1000000);
        rst_n = 1'b1;
        @(negedge clk);

        // Normal division, busy during iterations, single-cycle done
        dividend = 4'd13;
        divisor  = 4'd4;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("d13_busy", busy, 1);
        wait_done(lat);
        check("d13_lat", lat, 4);
        check("d13_q", quotient, 3);
        check("d13_r", remainder, 1);
        check("d13_res", result, 8'h13);
        check("d13_seg", dbz_seg, 7'b1000000);
        @(negedge clk);
        check("d13_pulse", done, 0);
        check("d13_hold", result, 8'h13);

        // Divide by zero then clear
        run_div(4'd7, 4'd0, "dbz7");
        @(negedge clk);
        check("dbz_hold_seg", dbz_seg, 7'b1111001);
        run_div(4'd15, 4'd1, "d15_1");

        // Dividend smaller than divisor, equal operands
        run_div(4'd3, 4'd9, "d3_9");
        run_div(4'd15, 4'd15, "d15_15");

        // start held high with operands changing mid-operation
        @(negedge clk);
        dividend = 4'd12;
        divisor  = 4'd5;
        start    = 1'b1;
        @(negedge clk);
        dividend = 4'd2;
        divisor  = 4'd1;
        wait_done(lat);
        check("hold1_lat", lat, 4);
        check("hold1_q", quotient, 2);
        check("hold1_r", remainder, 2);
        @(negedge clk);
        start = 1'b0;
        check("hold2_busy", busy, 1);
        wait_done(lat);
        check("hold2_lat", lat, 4);
        check("hold2_q", quotient, 2);
        check("hold2_r", remainder, 0);

        // Asynchronous reset mid-division
        @(negedge clk);
        dividend = 4'd14;
        divisor  = 4'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_q", quotient, 0);
        check("arst_r", remainder, 0);
        check("arst_res", result, 0);
        check("arst_seg", dbz_seg, 7'b1000000);
        #1 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("arst_nodone", seen, 0);
        run_div(4'd14, 4'd3, "d14_3");

        // Exhaustive sweep with random gaps (including back-to-back)
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                run_div(4'(a), 4'(b), $sformatf("sw_%0d_%0d", a, b));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
